if_fetch_align: RTL and testbench

Instruction-fetch alignment stage for the RV32IMC core, sitting directly upstream of the IF/ID pipeline register. It drives the word address of the synchronous instruction memory and accepts the returned 32-bit words. From the halfword-granular PC it assembles one complete instruction per cycle: either 16-bit compressed, or 32-bit and possibly straddling a word boundary. It then presents `if_inst`, `if_PC` and `if_pc4` to IF/ID. Decompression is not done here; compressed instructions leave zero-extended in the low half.

---
 rtl/if_fetch_align.sv | 138 +++++++++++++
 tb/tb_if_fetch_align.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_align.sv
// Purpose : RV32IMC fetch alignment; builds one 16/32-bit instruction per cycle from word-wide INSTMEM reads.
// Latency : outputs are combinational from registered state and imem_rdata; 1 fill cycle after reset/redirect (2 for halfword targets).
// Backpr. : stall holds all state and re-reads the same word so every output stays stable; redirect overrides stall.
//
// Ports:
//   clk, nrst             clock, asynchronous active-low reset
//   stall                 downstream cannot accept this cycle
//   redirect, redirect_pc taken branch/jump and its byte target (bit 0 ignored)
//   imem_addr, imem_rdata word address to INSTMEM, data for the previous cycle's address
//   if_valid, if_inst, if_PC, if_pc4, if_is_c   aligned instruction towards IF/ID

`ifndef PC_ADDR_BITS
`define PC_ADDR_BITS 32
`endif

module if_fetch_align #(
  parameter int                ADDR_W   = `PC_ADDR_BITS,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-3:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic              if_valid,
  output logic [31:0]       if_inst,
  output logic [ADDR_W-1:0] if_PC,
  output logic [ADDR_W-1:0] if_pc4,
  output logic              if_is_c
);

  localparam int WP_W = ADDR_W - 2;
  localparam logic [WP_W-1:0]   WP_ONE    = WP_W'(1);
  localparam logic [ADDR_W-1:0] PC_TWO    = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] PC_FOUR   = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] HALF_MASK = ~ADDR_W'(1);

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [WP_W-1:0]   word_ptr;      // word whose data is on imem_rdata this cycle
  logic [WP_W-1:0]   word_ptr_next;
  logic [15:0]       hbuf;          // upper half of the previous word, sits at pc
  logic              hbuf_v;

  logic run;
  logic hbuf_is_c;
  logic w_is_c;
  logic case_a, case_b, case_c, case_d, case_e;
  logic issue_c;
  logic [31:0]       inst_raw;
  logic [ADDR_W-1:0] pc_step;

  assign run       = (state == RUN);
  assign hbuf_is_c = (hbuf[1:0] != 2'b11);
  assign w_is_c    = (imem_rdata[1:0] != 2'b11);

  // Exactly one of these holds while running.
  assign case_a = run &  hbuf_v &  hbuf_is_c;           // buffered compressed half
  assign case_b = run &  hbuf_v & ~hbuf_is_c;           // 32-bit straddling two words
  assign case_c = run & ~hbuf_v & ~pc[1] &  w_is_c;     // compressed in low half of W
  assign case_d = run & ~hbuf_v & ~pc[1] & ~w_is_c;     // aligned 32-bit
  assign case_e = run & ~hbuf_v &  pc[1];               // unaligned target: only buffer upper half

  // Case A reuses the word already on imem_rdata, so the pointer does not move.
  always_comb begin
    word_ptr_next = word_ptr;
    if (redirect) begin
      word_ptr_next = redirect_pc[ADDR_W-1:2];
    end else if (!stall && run && !case_a) begin
      word_ptr_next = word_ptr + WP_ONE;
    end
  end

  assign imem_addr = word_ptr_next;

  always_comb begin
    inst_raw = '0;
    issue_c  = 1'b0;
    if (case_a) begin
      inst_raw = {16'h0, hbuf};
      issue_c  = 1'b1;
    end else if (case_b) begin
      inst_raw = {imem_rdata[15:0], hbuf};
    end else if (case_c) begin
      inst_raw = {16'h0, imem_rdata[15:0]};
      issue_c  = 1'b1;
    end else if (case_d) begin
      inst_raw = imem_rdata;
    end
  end

  assign if_valid = run & ~redirect & ~case_e;
  assign if_inst  = if_valid ? inst_raw : 32'h0;
  assign if_is_c  = if_valid & issue_c;
  assign pc_step  = if_is_c ? PC_TWO : PC_FOUR;
  assign if_PC    = pc;
  assign if_pc4   = pc + pc_step;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= FILL;
      pc       <= RESET_PC;
      word_ptr <= RESET_PC[ADDR_W-1:2];
      hbuf     <= '0;
      hbuf_v   <= 1'b0;
    end else begin
      word_ptr <= word_ptr_next;
      if (redirect) begin
        pc     <= redirect_pc & HALF_MASK;
        hbuf_v <= 1'b0;
        state  <= FILL;
      end else if (!stall) begin
        if (!run) begin
          state <= RUN;
        end else begin
          // if_valid here means an instruction was issued (not case E).
          if (if_valid) begin
            pc <= if_pc4;
          end
          if (case_a) begin
            hbuf_v <= 1'b0;
          end else if (case_b || case_c || case_e) begin
            hbuf   <= imem_rdata[31:16];
            hbuf_v <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_align.sv
module tb_if_fetch_align;

  localparam int ADDR_W = 10;
  localparam int WP_W   = ADDR_W - 2;
  localparam int NWORDS = 1 << WP_W;
  localparam logic [ADDR_W-1:0] RESET_PC = '0;

  logic              clk = 1'b0;
  logic              nrst = 1'b1;
  logic              stall = 1'b0;
  logic              redirect = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic [WP_W-1:0]   imem_addr;
  logic [31:0]       imem_rdata;
  logic              if_valid;
  logic [31:0]       if_inst;
  logic [ADDR_W-1:0] if_PC;
  logic [ADDR_W-1:0] if_pc4;
  logic              if_is_c;

  logic [31:0] mem [NWORDS];

  int n_cmp = 0;
  int n_bad = 0;

  if_fetch_align #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .nrst(nrst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_inst(if_inst), .if_PC(if_PC), .if_pc4(if_pc4), .if_is_c(if_is_c)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory: data one cycle after the address.
  always @(posedge clk) imem_rdata <= mem[imem_addr];

  // ---------------- reference model: instruction at a halfword address ----------------
  function automatic logic [15:0] half_at(input logic [ADDR_W-1:0] a);
    logic [31:0] w;
    w = mem[a[ADDR_W-1:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  function automatic bit ref_is_c(input logic [ADDR_W-1:0] a);
    logic [15:0] lo;
    lo = half_at(a);
    return lo[1:0] != 2'b11;
  endfunction

  function automatic logic [31:0] ref_inst(input logic [ADDR_W-1:0] a);
    logic [15:0] lo;
    lo = half_at(a);
    if (lo[1:0] != 2'b11) return {16'h0, lo};
    return {half_at(a + ADDR_W'(2)), lo};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input bit s, input bit r, input logic [ADDR_W-1:0] p);
    @(negedge clk);
    stall = s; redirect = r; redirect_pc = p;
    #1;
  endtask

  // Leaves the bench at the sample point of cycle 0 (the FILL cycle).
  task automatic do_reset();
    @(negedge clk);
    nrst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    @(negedge clk);
    nrst = 1'b1;
    #1;
  endtask

  task automatic fill_nop();
    for (int i = 0; i < NWORDS; i++) mem[i] = 32'h00000013;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [ADDR_W-1:0] exp_pc4;
    logic [WP_W-1:0]   exp_addr;
    exp_pc4  = RESET_PC + ADDR_W'(4);
    exp_addr = WP_W'(RESET_PC >> 2);
    fill_nop();
    #2 nrst = 1'b0;
    #1;
    n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL reset.valid got %b want 0", if_valid); end
    n_cmp++; if (if_inst !== 32'h0) begin n_bad++; $display("FAIL reset.inst got %h want 0", if_inst); end
    n_cmp++; if (if_is_c !== 1'b0) begin n_bad++; $display("FAIL reset.is_c got %b want 0", if_is_c); end
    n_cmp++; if (if_PC !== RESET_PC) begin n_bad++; $display("FAIL reset.PC got %h want %h", if_PC, RESET_PC); end
    n_cmp++; if (if_pc4 !== exp_pc4) begin n_bad++; $display("FAIL reset.pc4 got %h want %h", if_pc4, exp_pc4); end
    n_cmp++; if (imem_addr !== exp_addr) begin n_bad++; $display("FAIL reset.imem_addr got %h want %h", imem_addr, exp_addr); end
  endtask

  task automatic test_aligned();
    fill_nop();
    mem[0] = 32'h00500093;
    mem[1] = 32'h00A00113;
    do_reset();
    n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL aligned.c0.valid got %b want 0", if_valid); end
    cyc(0, 0, '0);
    n_cmp++; if (if_valid !== 1'b1) begin n_bad++; $display("FAIL aligned.c1.valid got %b want 1", if_valid); end
    n_cmp++; if (if_inst !== 32'h00500093) begin n_bad++; $display("FAIL aligned.c1.inst got %h want 00500093", if_inst); end
    n_cmp++; if (if_PC !== 10'd0) begin n_bad++; $display("FAIL aligned.c1.PC got %h want 0", if_PC); end
    n_cmp++; if (if_pc4 !== 10'd4) begin n_bad++; $display("FAIL aligned.c1.pc4 got %h want 4", if_pc4); end
    cyc(0, 0, '0);
    n_cmp++; if (if_inst !== 32'h00A00113) begin n_bad++; $display("FAIL aligned.c2.inst got %h want 00a00113", if_inst); end
    n_cmp++; if (if_PC !== 10'd4) begin n_bad++; $display("FAIL aligned.c2.PC got %h want 4", if_PC); end
    n_cmp++; if (if_pc4 !== 10'd8) begin n_bad++; $display("FAIL aligned.c2.pc4 got %h want 8", if_pc4); end
  endtask

  task automatic test_compressed_pair();
    fill_nop();
    mem[0] = 32'h45054501;
    do_reset();
    cyc(0, 0, '0);
    n_cmp++; if (if_inst !== 32'h00004501) begin n_bad++; $display("FAIL cpair.c1.inst got %h want 00004501", if_inst); end
    n_cmp++; if (if_is_c !== 1'b1) begin n_bad++; $display("FAIL cpair.c1.is_c got %b want 1", if_is_c); end
    n_cmp++; if (if_pc4 !== 10'd2) begin n_bad++; $display("FAIL cpair.c1.pc4 got %h want 2", if_pc4); end
    n_cmp++; if (imem_addr !== 8'd1) begin n_bad++; $display("FAIL cpair.c1.imem_addr got %h want 1", imem_addr); end
    cyc(0, 0, '0);
    n_cmp++; if (if_inst !== 32'h00004505) begin n_bad++; $display("FAIL cpair.c2.inst got %h want 00004505", if_inst); end
    n_cmp++; if (if_PC !== 10'd2) begin n_bad++; $display("FAIL cpair.c2.PC got %h want 2", if_PC); end
    n_cmp++; if (imem_addr !== 8'd1) begin n_bad++; $display("FAIL cpair.c2.imem_addr got %h want 1", imem_addr); end
  endtask

  task automatic test_straddle();
    logic [31:0] r;
    r = $urandom;
    fill_nop();
    mem[0] = 32'h00934501;
    mem[1] = {r[31:16], 16'h0050};
    do_reset();
    cyc(0, 0, '0);
    n_cmp++; if (if_PC !== 10'd0) begin n_bad++; $display("FAIL straddle.c1.PC got %h want 0", if_PC); end
    n_cmp++; if (if_inst !== 32'h00004501) begin n_bad++; $display("FAIL straddle.c1.inst got %h want 00004501", if_inst); end
    cyc(0, 0, '0);
    n_cmp++; if (if_PC !== 10'd2) begin n_bad++; $display("FAIL straddle.c2.PC got %h want 2", if_PC); end
    n_cmp++; if (if_inst !== 32'h00500093) begin n_bad++; $display("FAIL straddle.c2.inst got %h want 00500093", if_inst); end
    n_cmp++; if (if_is_c !== 1'b0) begin n_bad++; $display("FAIL straddle.c2.is_c got %b want 0", if_is_c); end
    n_cmp++; if (if_pc4 !== 10'd6) begin n_bad++; $display("FAIL straddle.c2.pc4 got %h want 6", if_pc4); end
  endtask

  task automatic test_unaligned_redirect(input bit with_stall);
    logic [31:0] r;
    r = $urandom;
    fill_nop();
    mem[1] = {16'h4585, r[15:0]};
    do_reset();
    cyc(0, 0, '0);
    cyc(0, 0, '0);
    cyc(with_stall, 1, 10'h006);
    n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL uredir%0d.n.valid got %b want 0", with_stall, if_valid); end
    n_cmp++; if (imem_addr !== 8'd1) begin n_bad++; $display("FAIL uredir%0d.n.imem_addr got %h want 1", with_stall, imem_addr); end
    cyc(0, 0, '0);
    n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL uredir%0d.n1.valid got %b want 0", with_stall, if_valid); end
    cyc(0, 0, '0);
    n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL uredir%0d.n2.valid got %b want 0", with_stall, if_valid); end
    cyc(0, 0, '0);
    n_cmp++; if (if_valid !== 1'b1) begin n_bad++; $display("FAIL uredir%0d.n3.valid got %b want 1", with_stall, if_valid); end
    n_cmp++; if (if_inst !== 32'h00004585) begin n_bad++; $display("FAIL uredir%0d.n3.inst got %h want 00004585", with_stall, if_inst); end
    n_cmp++; if (if_PC !== 10'd6) begin n_bad++; $display("FAIL uredir%0d.n3.PC got %h want 6", with_stall, if_PC); end
    n_cmp++; if (if_pc4 !== 10'd8) begin n_bad++; $display("FAIL uredir%0d.n3.pc4 got %h want 8", with_stall, if_pc4); end
  endtask

  task automatic test_stall();
    logic [31:0] r;
    fill_nop();
    for (int i = 0; i < 16; i++) begin
      r = $urandom;
      mem[i] = {r[31:2], 2'b11};
    end
    do_reset();
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, '0);
      n_cmp++; if (if_inst !== mem[k]) begin n_bad++; $display("FAIL stall.pre%0d.inst got %h want %h", k, if_inst, mem[k]); end
      n_cmp++; if (if_PC !== ADDR_W'(4 * k)) begin n_bad++; $display("FAIL stall.pre%0d.PC got %h want %h", k, if_PC, 4 * k); end
    end
    n_cmp++; if (imem_addr !== 8'd3) begin n_bad++; $display("FAIL stall.pre.imem_addr got %h want 3", imem_addr); end
    for (int k = 0; k < 3; k++) begin
      cyc(1, 0, '0);
      n_cmp++; if (if_inst !== mem[3]) begin n_bad++; $display("FAIL stall.hold%0d.inst got %h want %h", k, if_inst, mem[3]); end
      n_cmp++; if (if_PC !== 10'd12) begin n_bad++; $display("FAIL stall.hold%0d.PC got %h want c", k, if_PC); end
      n_cmp++; if (imem_addr !== 8'd3) begin n_bad++; $display("FAIL stall.hold%0d.imem_addr got %h want 3", k, imem_addr); end
    end
    cyc(0, 0, '0);
    n_cmp++; if (if_inst !== mem[3]) begin n_bad++; $display("FAIL stall.rel.inst got %h want %h", if_inst, mem[3]); end
    n_cmp++; if (if_PC !== 10'd12) begin n_bad++; $display("FAIL stall.rel.PC got %h want c", if_PC); end
    n_cmp++; if (imem_addr !== 8'd4) begin n_bad++; $display("FAIL stall.rel.imem_addr got %h want 4", imem_addr); end
    cyc(0, 0, '0);
    n_cmp++; if (if_inst !== mem[4]) begin n_bad++; $display("FAIL stall.next.inst got %h want %h", if_inst, mem[4]); end
    n_cmp++; if (if_PC !== 10'd16) begin n_bad++; $display("FAIL stall.next.PC got %h want 10", if_PC); end
  endtask

  task automatic test_async_reset();
    logic [31:0] exp_inst;
    fill_nop();
    mem[0] = 32'h45054501;
    mem[2] = 32'h00A00113;
    exp_inst = ref_inst(RESET_PC);
    do_reset();
    for (int k = 0; k < 4; k++) cyc(0, 0, '0);
    @(posedge clk);
    #3 nrst = 1'b0;
    #1;
    n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL areset.valid got %b want 0", if_valid); end
    n_cmp++; if (if_inst !== 32'h0) begin n_bad++; $display("FAIL areset.inst got %h want 0", if_inst); end
    n_cmp++; if (imem_addr !== WP_W'(RESET_PC >> 2)) begin n_bad++; $display("FAIL areset.imem_addr got %h want %h", imem_addr, RESET_PC >> 2); end
    @(negedge clk);
    nrst = 1'b1;
    #1;
    n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL areset.c0.valid got %b want 0", if_valid); end
    cyc(0, 0, '0);
    n_cmp++; if (if_valid !== 1'b1) begin n_bad++; $display("FAIL areset.c1.valid got %b want 1", if_valid); end
    n_cmp++; if (if_PC !== RESET_PC) begin n_bad++; $display("FAIL areset.c1.PC got %h want %h", if_PC, RESET_PC); end
    n_cmp++; if (if_inst !== exp_inst) begin n_bad++; $display("FAIL areset.c1.inst got %h want %h", if_inst, exp_inst); end
  endtask

  // Random program with random stalls and redirects, checked every cycle against
  // a model that only knows: the PC, how many fill cycles remain, and the memory.
  task automatic test_random();
    logic [31:0]       w;
    logic [ADDR_W-1:0] m_pc;
    int                m_bub;
    bit                s, r, exp_v, exp_c;
    logic [ADDR_W-1:0] p, exp_pc4;
    logic [31:0]       exp_inst;
    for (int i = 0; i < NWORDS; i++) begin
      w = $urandom;
      if ($urandom_range(0, 1) == 1) w[1:0] = 2'b11;
      if ($urandom_range(0, 1) == 1) w[17:16] = 2'b11;
      mem[i] = w;
    end
    do_reset();
    n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL rand.c0.valid got %b want 0", if_valid); end
    m_pc  = RESET_PC;
    m_bub = 0;
    for (int cyc_i = 1; cyc_i <= 4000; cyc_i++) begin
      s = ($urandom_range(0, 4) == 0);
      r = ($urandom_range(0, 24) == 0);
      p = ADDR_W'($urandom);
      cyc(s, r, p);
      exp_v = !r && (m_bub == 0);
      n_cmp++; if (if_valid !== exp_v) begin n_bad++; $display("FAIL rand.%0d.valid got %b want %b", cyc_i, if_valid, exp_v); end
      if (exp_v) begin
        exp_inst = ref_inst(m_pc);
        exp_c    = ref_is_c(m_pc);
        exp_pc4  = m_pc + (exp_c ? ADDR_W'(2) : ADDR_W'(4));
        n_cmp++; if (if_inst !== exp_inst) begin n_bad++; $display("FAIL rand.%0d.inst got %h want %h", cyc_i, if_inst, exp_inst); end
        n_cmp++; if (if_PC !== m_pc) begin n_bad++; $display("FAIL rand.%0d.PC got %h want %h", cyc_i, if_PC, m_pc); end
        n_cmp++; if (if_pc4 !== exp_pc4) begin n_bad++; $display("FAIL rand.%0d.pc4 got %h want %h", cyc_i, if_pc4, exp_pc4); end
        n_cmp++; if (if_is_c !== exp_c) begin n_bad++; $display("FAIL rand.%0d.is_c got %b want %b", cyc_i, if_is_c, exp_c); end
      end else begin
        n_cmp++; if (if_inst !== 32'h0) begin n_bad++; $display("FAIL rand.%0d.inst_idle got %h want 0", cyc_i, if_inst); end
      end
      if (r) begin
        m_pc  = p & ~ADDR_W'(1);
        m_bub = p[1] ? 2 : 1;
      end else if (!s) begin
        if (m_bub > 0) m_bub--;
        else m_pc = exp_pc4;
      end
    end
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_compressed_pair();
    test_straddle();
    test_unaligned_redirect(1'b0);
    test_unaligned_redirect(1'b1);
    test_stall();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
